action_cfg_ctrl: RTL and testbench

Control-path configurator for one action stage. Watches the stage's control AXI-Stream, consumes packets addressed to this stage's action resource, assembles a 2-beat action entry and issues a single-cycle write to the action RAM. All other packets pass through to the next stage on the control chain with one cycle of latency. It sits between the control input of a pipeline stage and the lookup-to-action path, upstream of the action engine's action source.

---
 rtl/action_cfg_ctrl_pkg.sv | 30 +++
 rtl/axis_fwd_reg.sv | 64 ++++++
 rtl/action_cfg_ctrl.sv | 142 ++++++++++++++
 tb/tb_action_cfg_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/action_cfg_ctrl_pkg.sv
// Shared control-path definitions for stage configurators: header field
// offsets/widths and the configurator FSM encoding.
package action_cfg_ctrl_pkg;

    localparam int CTRL_DATA_W = 512;
    localparam int MOD_ID_LSB  = 368;
    localparam int MOD_ID_W    = 8;
    localparam int IDX_LSB     = 384;
    localparam int STAGE_W     = 5;
    localparam int RES_W       = 3;
    localparam int ERR_CNT_W   = 16;

    typedef struct packed {
        logic [STAGE_W-1:0] stage;
        logic [RES_W-1:0]   res;
    } mod_id_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_PAY0  = 3'd2,
        ST_PAY1  = 3'd3,
        ST_FLUSH = 3'd4
    } cfg_state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axis_fwd_reg.sv
// One-stage AXIS register that captures a beat only when fwd_en is set.
// Latency 1 cycle; m_tvalid low on cycles with no forwarded beat.
// No backpressure: the register reloads every cycle fwd_en is high.
module axis_fwd_reg #(
    parameter int DATA_W = 512,
    parameter int USER_W = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [USER_W-1:0]   s_tuser,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tlast,
    input  logic                fwd_en,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [USER_W-1:0]   m_tuser,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tvalid,
    output logic                m_tlast
);

    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [USER_W-1:0]   tuser_q, tuser_d;
    logic [DATA_W/8-1:0] tkeep_q, tkeep_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;

    always_comb begin
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = fwd_en;
        if (fwd_en) begin
            tdata_d = s_tdata;
            tuser_d = s_tuser;
            tkeep_d = s_tkeep;
            tlast_d = s_tlast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q  <= '0;
            tuser_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tuser  = tuser_q;
    assign m_tkeep  = tkeep_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;

endmodule

// File: rtl/action_cfg_ctrl.sv
// Action-table configurator: consumes control packets for this stage's action
// resource and writes a 2-beat entry; other packets forward with 1 cycle latency.
// No backpressure: every valid beat is accepted, one beat per cycle sustained.
module action_cfg_ctrl
    import action_cfg_ctrl_pkg::*;
#(
    parameter logic [STAGE_W-1:0] STAGE_ID             = 5'd0,
    parameter logic [RES_W-1:0]   ACT_ID               = 3'd3,
    parameter int                 C_S_AXIS_DATA_WIDTH  = CTRL_DATA_W,
    parameter int                 C_S_AXIS_TUSER_WIDTH = 128,
    parameter int                 ENTRY_W              = 625,
    parameter int                 ADDR_W               = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic                              cfg_wr_en,
    output logic [ADDR_W-1:0]                 cfg_wr_addr,
    output logic [ENTRY_W-1:0]                cfg_wr_data,
    output logic [ERR_CNT_W-1:0]              cfg_err_cnt
);

    cfg_state_e                     state_q, state_d;
    logic [ADDR_W-1:0]              idx_q, idx_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0] hi_q, hi_d;
    logic                           wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
    logic [ENTRY_W-1:0]             wr_data_q, wr_data_d;
    logic [ERR_CNT_W-1:0]           err_cnt_q, err_cnt_d;
    logic                           fwd_en;
    mod_id_t                        hdr_mod_id;
    logic                           hdr_match;

    assign hdr_mod_id = mod_id_t'(c_s_axis_tdata[MOD_ID_LSB +: MOD_ID_W]);
    assign hdr_match  = (hdr_mod_id.stage == STAGE_ID) && (hdr_mod_id.res == ACT_ID);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_cnt_d = err_cnt_q;
        fwd_en    = 1'b0;
        if (c_s_axis_tvalid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hdr_match) begin
                        // A header with tlast carries no entry at all.
                        if (c_s_axis_tlast) begin
                            err_cnt_d = sat_inc(err_cnt_q);
                        end else begin
                            idx_d   = c_s_axis_tdata[IDX_LSB +: ADDR_W];
                            state_d = ST_PAY0;
                        end
                    end else begin
                        fwd_en = 1'b1;
                        if (!c_s_axis_tlast) state_d = ST_FWD;
                    end
                end
                ST_FWD: begin
                    fwd_en = 1'b1;
                    if (c_s_axis_tlast) state_d = ST_IDLE;
                end
                ST_PAY0: begin
                    hi_d = c_s_axis_tdata;
                    if (c_s_axis_tlast) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_PAY1;
                    end
                end
                ST_PAY1: begin
                    // Entry is the top ENTRY_W bits of {hi, second payload beat}.
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = {hi_q, c_s_axis_tdata[C_S_AXIS_DATA_WIDTH-1 -: ENTRY_W-C_S_AXIS_DATA_WIDTH]};
                    state_d   = c_s_axis_tlast ? ST_IDLE : ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (c_s_axis_tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cfg_wr_en   = wr_en_q;
    assign cfg_wr_addr = wr_addr_q;
    assign cfg_wr_data = wr_data_q;
    assign cfg_err_cnt = err_cnt_q;

    axis_fwd_reg #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_fwd (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (c_s_axis_tdata),
        .s_tuser  (c_s_axis_tuser),
        .s_tkeep  (c_s_axis_tkeep),
        .s_tlast  (c_s_axis_tlast),
        .fwd_en   (fwd_en),
        .m_tdata  (c_m_axis_tdata),
        .m_tuser  (c_m_axis_tuser),
        .m_tkeep  (c_m_axis_tkeep),
        .m_tvalid (c_m_axis_tvalid),
        .m_tlast  (c_m_axis_tlast)
    );

endmodule

// File: tb/tb_action_cfg_ctrl.sv
// Self-checking bench for action_cfg_ctrl: directed vector table, reset-in-packet
// sequence and randomized packet stream against a packet-position reference model.
module tb_action_cfg_ctrl;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = 64;
    localparam int EW = 625;
    localparam int AW = 4;
    localparam logic [4:0] TB_STAGE = 5'd0;
    localparam logic [2:0] TB_ACT   = 3'd3;
    localparam logic [7:0] MATCH_ID = {TB_STAGE, TB_ACT};

    typedef logic [1023:0] w_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  c_s_axis_tdata;
    logic [UW-1:0]  c_s_axis_tuser;
    logic [KW-1:0]  c_s_axis_tkeep;
    logic           c_s_axis_tvalid;
    logic           c_s_axis_tlast;
    logic [DW-1:0]  c_m_axis_tdata;
    logic [UW-1:0]  c_m_axis_tuser;
    logic [KW-1:0]  c_m_axis_tkeep;
    logic           c_m_axis_tvalid;
    logic           c_m_axis_tlast;
    logic           cfg_wr_en;
    logic [AW-1:0]  cfg_wr_addr;
    logic [EW-1:0]  cfg_wr_data;
    logic [15:0]    cfg_err_cnt;

    always #5 clk = ~clk;

    action_cfg_ctrl #(
        .STAGE_ID             (TB_STAGE),
        .ACT_ID               (TB_ACT),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .ENTRY_W              (EW),
        .ADDR_W               (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .c_s_axis_tdata  (c_s_axis_tdata),
        .c_s_axis_tuser  (c_s_axis_tuser),
        .c_s_axis_tkeep  (c_s_axis_tkeep),
        .c_s_axis_tvalid (c_s_axis_tvalid),
        .c_s_axis_tlast  (c_s_axis_tlast),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_addr     (cfg_wr_addr),
        .cfg_wr_data     (cfg_wr_data),
        .cfg_err_cnt     (cfg_err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: tracks beat position inside the current packet.
    int            m_pos;
    logic          m_match;
    logic [AW-1:0] m_idx;
    logic [DW-1:0] m_hi;
    logic          e_mvld;
    logic [DW-1:0] e_mdat;
    logic [UW-1:0] e_muser;
    logic [KW-1:0] e_mkeep;
    logic          e_mlast;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [EW-1:0] e_data;
    logic [15:0]   e_err;

    typedef struct {
        logic        vld;
        logic        hdr;
        logic [7:0]  mod;
        logic [3:0]  idx;
        logic [7:0]  fill;
        logic        last;
        logic        e_mvld;
        logic        e_wr;
        logic [15:0] e_err;
    } vec_t;

    localparam int NV = 32;
    vec_t vt [NV];

    task automatic chk(input string nm, input w_t a, input w_t e);
        int b;
        b = 0;
        n_tests++;
        if (a !== e) begin
            n_fail++;
            for (int i = 1023; i >= 0; i--) if (a[i] !== e[i]) b = i;
            $display("FAIL %s: first diff bit %0d, act[window]=%h exp[window]=%h",
                     nm, b, a[(b/64)*64 +: 64], e[(b/64)*64 +: 64]);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_match = 1'b0; m_idx = '0; m_hi = '0;
        e_mvld = 1'b0; e_mdat = '0; e_muser = '0; e_mkeep = '0; e_mlast = 1'b0;
        e_wr = 1'b0; e_addr = '0; e_data = '0; e_err = '0;
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic [UW-1:0] u,
                              input logic [KW-1:0] k, input logic l);
        logic [2*DW-1:0] full;
        e_mvld = 1'b0;
        e_wr   = 1'b0;
        if (v) begin
            if (m_pos == 0) begin
                m_match = (d[375:368] == MATCH_ID);
                m_idx   = d[384 +: AW];
            end
            if (!m_match) begin
                e_mvld = 1'b1; e_mdat = d; e_muser = u; e_mkeep = k; e_mlast = l;
            end else begin
                if (m_pos == 1) m_hi = d;
                if (m_pos == 2) begin
                    full   = {m_hi, d};
                    e_wr   = 1'b1;
                    e_addr = m_idx;
                    e_data = full[2*DW-1 -: EW];
                end
                if (l && m_pos < 2 && e_err != 16'hFFFF) e_err = e_err + 16'd1;
            end
            m_pos = l ? 0 : m_pos + 1;
        end
    endtask

    task automatic check_all();
        chk("m_tvalid", w_t'(c_m_axis_tvalid), w_t'(e_mvld));
        if (e_mvld) begin
            chk("m_tdata", w_t'(c_m_axis_tdata), w_t'(e_mdat));
            chk("m_tuser", w_t'(c_m_axis_tuser), w_t'(e_muser));
            chk("m_tkeep", w_t'(c_m_axis_tkeep), w_t'(e_mkeep));
            chk("m_tlast", w_t'(c_m_axis_tlast), w_t'(e_mlast));
        end
        chk("wr_en",   w_t'(cfg_wr_en),   w_t'(e_wr));
        chk("wr_addr", w_t'(cfg_wr_addr), w_t'(e_addr));
        chk("wr_data", w_t'(cfg_wr_data), w_t'(e_data));
        chk("err_cnt", w_t'(cfg_err_cnt), w_t'(e_err));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_m_tvalid"}, w_t'(c_m_axis_tvalid), '0);
        chk({pfx, "_m_tdata"},  w_t'(c_m_axis_tdata),  '0);
        chk({pfx, "_m_tuser"},  w_t'(c_m_axis_tuser),  '0);
        chk({pfx, "_m_tkeep"},  w_t'(c_m_axis_tkeep),  '0);
        chk({pfx, "_m_tlast"},  w_t'(c_m_axis_tlast),  '0);
        chk({pfx, "_wr_en"},    w_t'(cfg_wr_en),       '0);
        chk({pfx, "_wr_addr"},  w_t'(cfg_wr_addr),     '0);
        chk({pfx, "_wr_data"},  w_t'(cfg_wr_data),     '0);
        chk({pfx, "_err_cnt"},  w_t'(cfg_err_cnt),     '0);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [UW-1:0] u,
                         input logic [KW-1:0] k, input logic l);
        c_s_axis_tvalid = v;
        c_s_axis_tdata  = d;
        c_s_axis_tuser  = u;
        c_s_axis_tkeep  = k;
        c_s_axis_tlast  = l;
        @(posedge clk);
        model_step(v, d, u, k, l);
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] mk_beat(input logic hdr, input logic [7:0] mod,
                                              input logic [3:0] idx, input logic [7:0] fill);
        logic [DW-1:0] d;
        d = {64{fill}};
        if (hdr) begin
            d[375:368] = mod;
            d[387:384] = idx;
        end
        return d;
    endfunction

    function automatic vec_t mk(input logic v, input logic h, input logic [7:0] mod,
                                input logic [3:0] idx, input logic [7:0] fill, input logic l,
                                input logic em, input logic ew, input logic [15:0] ee);
        vec_t r;
        r.vld = v; r.hdr = h; r.mod = mod; r.idx = idx; r.fill = fill; r.last = l;
        r.e_mvld = em; r.e_wr = ew; r.e_err = ee;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [DW-1:0]   d;
        logic [1023:0]   plan_full;
        logic [EW-1:0]   plan_data;
        logic [7:0]      mod;
        int              len;
        int              cls;

        // Non-matching 3-beat packet
        vt[0]  = mk(1, 1, 8'h08, 4'h0, 8'h11, 0,  1, 0, 16'd0);
        vt[1]  = mk(1, 0, 8'h00, 4'h0, 8'h22, 0,  1, 0, 16'd0);
        vt[2]  = mk(1, 0, 8'h00, 4'h0, 8'h33, 1,  1, 0, 16'd0);
        // Matching 3-beat packet, idx 5
        vt[3]  = mk(1, 1, 8'h03, 4'h5, 8'h00, 0,  0, 0, 16'd0);
        vt[4]  = mk(1, 0, 8'h00, 4'h0, 8'hAA, 0,  0, 0, 16'd0);
        vt[5]  = mk(1, 0, 8'h00, 4'h0, 8'h55, 1,  0, 1, 16'd0);
        // Truncated on PAY0, then a non-matching packet
        vt[6]  = mk(1, 1, 8'h03, 4'h2, 8'h00, 0,  0, 0, 16'd0);
        vt[7]  = mk(1, 0, 8'h00, 4'h0, 8'hCC, 1,  0, 0, 16'd1);
        vt[8]  = mk(1, 1, 8'h08, 4'h0, 8'h44, 0,  1, 0, 16'd1);
        vt[9]  = mk(1, 0, 8'h00, 4'h0, 8'h45, 1,  1, 0, 16'd1);
        // Matching header with tlast
        vt[10] = mk(1, 1, 8'h03, 4'h6, 8'h00, 1,  0, 0, 16'd2);
        // Matching 5-beat packet with 2-cycle gaps (gap beats carry junk + tlast)
        vt[11] = mk(1, 1, 8'h03, 4'h9, 8'h00, 0,  0, 0, 16'd2);
        vt[12] = mk(0, 1, 8'h08, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[13] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[14] = mk(1, 0, 8'h00, 4'h0, 8'h0F, 0,  0, 0, 16'd2);
        vt[15] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[16] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[17] = mk(1, 0, 8'h00, 4'h0, 8'hF0, 0,  0, 1, 16'd2);
        vt[18] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[19] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[20] = mk(1, 0, 8'h00, 4'h0, 8'h77, 0,  0, 0, 16'd2);
        vt[21] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[22] = mk(0, 0, 8'h00, 4'h0, 8'hFF, 1,  0, 0, 16'd2);
        vt[23] = mk(1, 0, 8'h00, 4'h0, 8'h88, 1,  0, 0, 16'd2);
        // Back-to-back: non-matching, matching, non-matching
        vt[24] = mk(1, 1, 8'h08, 4'h0, 8'h61, 0,  1, 0, 16'd2);
        vt[25] = mk(1, 0, 8'h00, 4'h0, 8'h62, 1,  1, 0, 16'd2);
        vt[26] = mk(1, 1, 8'h03, 4'hC, 8'h63, 0,  0, 0, 16'd2);
        vt[27] = mk(1, 0, 8'h00, 4'h0, 8'h64, 0,  0, 0, 16'd2);
        vt[28] = mk(1, 0, 8'h00, 4'h0, 8'h65, 1,  0, 1, 16'd2);
        vt[29] = mk(1, 1, 8'h10, 4'h0, 8'h66, 1,  1, 0, 16'd2);
        // Partial field matches must not be consumed
        vt[30] = mk(1, 1, 8'h0B, 4'h0, 8'h67, 1,  1, 0, 16'd2);
        vt[31] = mk(1, 1, 8'h04, 4'h0, 8'h68, 1,  1, 0, 16'd2);

        plan_full = {{64{8'hAA}}, {64{8'h55}}};
        plan_data = plan_full[1023 -: EW];

        rst_n = 1'b0;
        c_s_axis_tvalid = 1'b0; c_s_axis_tdata = '0; c_s_axis_tuser = '0;
        c_s_axis_tkeep = '0; c_s_axis_tlast = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            d = mk_beat(vt[i].hdr, vt[i].mod, vt[i].idx, vt[i].fill);
            drive(vt[i].vld, d, {16{vt[i].fill}}, {8{vt[i].fill}}, vt[i].last);
            chk($sformatf("vec%0d_mvld", i), w_t'(c_m_axis_tvalid), w_t'(vt[i].e_mvld));
            chk($sformatf("vec%0d_wr_en", i), w_t'(cfg_wr_en), w_t'(vt[i].e_wr));
            chk($sformatf("vec%0d_err", i), w_t'(cfg_err_cnt), w_t'(vt[i].e_err));
            if (i == 5) begin
                chk("plan_wr_addr", w_t'(cfg_wr_addr), w_t'(4'h5));
                chk("plan_wr_data", w_t'(cfg_wr_data), w_t'(plan_data));
            end
        end

        // Reset while waiting for the first payload beat of a matching packet
        drive(1'b1, mk_beat(1'b1, MATCH_ID, 4'h1, 8'h00), '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero("midrst");
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, {64{8'hAA}}, {16{8'h5A}}, {8{8'hA5}}, 1'b1);
        chk("leftover_fwd", w_t'(c_m_axis_tvalid), w_t'(1'b1));
        chk("leftover_tdata", w_t'(c_m_axis_tdata), w_t'({64{8'hAA}}));
        chk("leftover_nowr", w_t'(cfg_wr_en), '0);

        // Randomized packet stream
        for (int p = 0; p < 300; p++) begin
            len = $urandom_range(1, 6);
            cls = $urandom_range(0, 3);
            mod = (cls == 1) ? 8'h08 : (cls == 2) ? 8'($urandom) : MATCH_ID;
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 2))
                        drive(1'b0, rnd512(), {$urandom, $urandom, $urandom, $urandom},
                              {$urandom, $urandom}, 1'($urandom));
                d = rnd512();
                if (b == 0) d[375:368] = mod;
                drive(1'b1, d, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom}, (b == len - 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
